// File: rtl/uart_result_tx_if.sv
// Producer-side handshake and serial line bundle for uart_result_tx.
// The master modport is the byte producer; the slave modport is the transmitter.
interface uart_result_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       txd;
    logic       busy;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  txd,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output txd,
        output busy
    );
endinterface

// File: rtl/uart_result_tx.sv
// FIFO-buffered UART transmitter for result bytes; 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input logic        clk,
    input logic        reset,
    uart_result_tx_if.slave bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              txd_q;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    logic       data_ready;
    logic       baud_done;
    logic       push;
    logic       pop;
    logic [7:0] head;

    // Ready depends only on the registered count, so a pop on the same edge
    // never lets a byte slip into a full FIFO.
    assign data_ready = (count != CNT_W'(FIFO_DEPTH));
    assign baud_done  = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign push       = bus.data_valid && data_ready && !reset;
    assign pop        = (count != '0) &&
                        ((state == S_IDLE) || ((state == S_STOP) && baud_done));
    assign head       = mem[rd_ptr];

    assign bus.data_ready = data_ready;
    assign bus.txd        = txd_q;
    assign bus.busy       = (state != S_IDLE) || (count != '0);

    // NOTE: FIFO storage is deliberately not reset; emptiness is tracked by
    // count and the pointers, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            txd_q   <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                shreg  <= head;
`ifdef UART_TX_PARITY_EN
                parity_q <= ^head;
`endif
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                S_IDLE: begin
                    baud  <= '0;
                    txd_q <= 1'b1;
                    if (pop) begin
                        state <= S_START;
                        txd_q <= 1'b0;
                    end
                end

                S_START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        txd_q   <= shreg[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            txd_q <= parity_q;
`else
                            state <= S_STOP;
                            txd_q <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            txd_q   <= shreg[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= S_STOP;
                        txd_q <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        // Chain straight into the next frame when data is waiting.
                        if (pop) begin
                            state <= S_START;
                            txd_q <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            txd_q <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    txd_q <= 1'b1;
                    baud  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed self-checking bench for uart_result_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Drives on falling edges and samples on falling edges, away from the active edge.
module tb_uart_result_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_result_tx_if bus ();

    uart_result_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Samples one full frame, starting at the negedge after the frame's start edge.
    task automatic check_frame(input logic [7:0] b, input string name);
        logic [10:0] bits;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9]  = ^b;
        bits[10] = 1'b1;
`else
        bits[9]  = 1'b1;
        bits[10] = 1'b1;
`endif
        for (int k = 0; k < FRAME_BITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                n_checks++;
                if (bus.txd !== bits[k]) begin
                    n_fail++;
                    $display("FAIL %s frame %h bit %0d cycle %0d: txd=%b expected %b",
                             name, b, k, c, bus.txd, bits[k]);
                end
            end
        end
    endtask

    task automatic check_idle_after(input string name);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_last_cycle: busy=%b expected 1", name, bus.busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.txd !== 1'b1 || bus.data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_after: busy=%b txd=%b ready=%b expected 0 1 1",
                     name, bus.busy, bus.txd, bus.data_ready);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h55;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: txd=%b busy=%b ready=%b expected 1 0 1",
                     bus.txd, bus.busy, bus.data_ready);
        end
        reset          = 1'b0;
        bus.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.txd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_accept: busy=%b txd=%b expected 0 1", bus.busy, bus.txd);
        end
    endtask

    task automatic send_and_check(input logic [7:0] b, input string name);
        @(negedge clk);
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.data_in    = ~b;
        n_checks++;
        if (bus.txd !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_latency: txd=%b expected 1 before E+1", name, bus.txd);
        end
        check_frame(b, name);
        check_idle_after(name);
    endtask

    task automatic test_single_frame();
        send_and_check(8'hA5, "single_a5");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        logic       exp_ready [6];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    bus.data_in    = bytes[i];
                    bus.data_valid = 1'b1;
                    n_checks++;
                    if (bus.data_ready !== exp_ready[i]) begin
                        n_fail++;
                        $display("FAIL b2b_ready attempt %0d: ready=%b expected %b",
                                 i, bus.data_ready, exp_ready[i]);
                    end
                end
                @(negedge clk);
                bus.data_valid = 1'b0;
                bus.data_in    = 8'h00;
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 5; i++) check_frame(bytes[i], "b2b");
            end
        join
        check_idle_after("b2b");
    endtask

    task automatic test_full_pop_collision();
        logic [7:0] bytes [5];
        bytes = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h81};
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    bus.data_in    = bytes[i];
                    bus.data_valid = 1'b1;
                end
                // FIFO holds four bytes from here until the first frame's stop ends.
                for (int j = 5; j <= 41; j++) begin
                    @(negedge clk);
                    bus.data_in    = 8'hFF;
                    bus.data_valid = 1'b1;
                    n_checks++;
                    if (bus.data_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL full_ready_low cycle %0d: ready=%b expected 0",
                                 j, bus.data_ready);
                    end
                end
                @(negedge clk);
                n_checks++;
                if (bus.data_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL collision_ready_high: ready=%b expected 1", bus.data_ready);
                end
                bus.data_valid = 1'b0;
                bus.data_in    = 8'h00;
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 5; i++) check_frame(bytes[i], "collision");
            end
        join
        check_idle_after("collision");
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        @(negedge clk); bus.data_in = 8'h3C; bus.data_valid = 1'b1;
        @(negedge clk); bus.data_in = 8'h11;
        @(negedge clk); bus.data_in = 8'h22;
        @(negedge clk); bus.data_valid = 1'b0; bus.data_in = 8'h00;
        repeat (7) @(negedge clk);
        n_checks++;
        if (bus.txd !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_bit1: txd=%b busy=%b expected 0 1", bus.txd, bus.busy);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.txd !== 1'b1 || bus.data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_bit3: txd=%b ready=%b expected 1 1", bus.txd, bus.data_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_after: txd=%b busy=%b ready=%b expected 1 0 1",
                     bus.txd, bus.busy, bus.data_ready);
        end
        reset = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midreset_no_frames: %0d non-idle cycles, expected 0", bad);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        send_and_check(8'h07, "parity_07");
        send_and_check(8'h03, "parity_03");
    endtask
`endif

    initial begin
        bus.data_in    = 8'h00;
        bus.data_valid = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_full_pop_collision();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_result_tx.md
UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, CLK cycles per UART bit (10 MHz / 115200); legal range 2..4095.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-005 DATA_IN  input  8  byte to transmit, typically a MULT_DONE result byte from the core.
REQ-006 DATA_VALID  input  1  producer asserts while DATA_IN is valid.
REQ-007 DATA_READY  output  1  high when the FIFO can accept a byte.
REQ-008 TXD  output  1  serial line to host, registered, idle high.
REQ-009 BUSY  output  1  high while a frame is in flight or the FIFO is non-empty.

Function
REQ-010 Byte SHALL be accepted on a rising edge where DATA_VALID and DATA_READY are both high; one byte per edge.
REQ-011 DATA_READY SHALL be low exactly when FIFO count equals FIFO_DEPTH, independent of a same-cycle pop (no push-through when full).
REQ-012 DATA_VALID while DATA_READY is low SHALL have no effect; DATA_IN is not captured and the FIFO is unchanged.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only with UART_TX_PARITY_EN), STOP.
REQ-014 IDLE: TXD=1; if FIFO non-empty, pop head into shift register and enter START on the same edge.
REQ-015 Byte accepted at edge E into an empty FIFO with FSM in IDLE: TXD SHALL be 0 from edge E+1.
REQ-016 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter 0..CLKS_PER_BIT-1 cleared on every state change.
REQ-017 START drives 0; DATA drives bits 0..7 LSB first with a 3-bit index; STOP drives 1 for exactly one bit time.
REQ-018 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-019 At STOP end, if FIFO non-empty, FSM SHALL pop and enter START on the same edge (no idle gap); otherwise enter IDLE.
REQ-020 Push and pop on the same edge SHALL leave count unchanged and preserve FIFO order.
REQ-021 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-022 BUSY SHALL be (state != IDLE) OR (count != 0), registered or combinational from registered state only.
REQ-023 DATA_IN SHALL be held stable in the FIFO; changes to DATA_IN after acceptance SHALL not affect the transmitted frame.

Reset
REQ-024 With RESET high at a rising edge: state=IDLE, TXD=1, FIFO empty, pointers and baud counter zero, DATA_READY=1, BUSY=0 after that edge.
REQ-025 RESET mid-frame SHALL abandon the frame and discard all FIFO contents; TXD SHALL be 1 from the reset edge.
REQ-026 DATA_VALID during RESET SHALL not be accepted.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, drives even parity (XOR of the 8 data bits) for one bit time.
REQ-028 UART_TX_PARITY_EN undefined: no PARITY state or parity logic; DATA goes directly to STOP (8N1).

Verification
REQ-029 CLKS_PER_BIT=4, send 0xA5 -> TXD from E+1: 0 then 1,0,1,0,0,1,0,1 then 1, each held 4 cycles; BUSY falls after 40 cycles.
REQ-030 FIFO_DEPTH=4, push 6 bytes back-to-back while TXD busy -> DATA_READY low once full; all accepted bytes sent in order, no idle cycles between frames.
REQ-031 Push on the same edge the FSM pops from a full FIFO -> push rejected, count drops to 3, DATA_READY high next cycle.
REQ-032 RESET asserted during DATA bit 3 of 0x3C with 2 bytes queued -> TXD=1, BUSY=0, DATA_READY=1 after the edge; no further frames.
REQ-033 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, frame 44 cycles; send 0x03 -> parity bit 0.
REQ-034 Hold DATA_VALID high with 0xFF while full for 100 cycles -> no extra bytes transmitted beyond those accepted.
